// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Shared RV32I fetch constants: default reset PC, bytes per
//                instruction word and the canonical NOP encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_BYTES       = 4;
    // addi x0, x0, 0
    localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous in-order queue of {inst, pc} entries.
//                Read/write pointers carry an extra wrap bit so that
//                full/empty need no separate flag. Synchronous flush.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    push       in   write push_data at the tail
//    push_data  in   2*width entry {inst, pc}
//    pop        in   drop the head entry
//    flush      in   empty the queue (wins over push/pop)
//    count      out  number of valid entries, 0..DEPTH
//    head       out  oldest entry (registered storage)
// ============================================================================
module fetch_fifo #(
    parameter int width = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [2*width-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2*width-1:0]       head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [2*width-1:0]   mem [DEPTH];

    // Storage is reset so the head reads as all-zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : RV32I instruction fetch stage. Generates sequential PCs,
//                issues word requests to instruction memory under a credit
//                limit (queued + in flight <= DEPTH), buffers returned words
//                in fetch_fifo and hands {inst, inst_pc} to the decoder over
//                valid/ready. A redirect flushes the queue and arranges for
//                in-flight responses to be dropped.
//  Config      : FETCH_BYPASS_EN - when defined, a kept response is forwarded
//                combinationally to the decoder while the queue is empty.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n         clock (rising) / async active-low reset
//    imem_req_valid     out  fetch request valid
//    imem_req_ready     in   memory accepts request
//    imem_req_addr      out  word-aligned fetch address
//    imem_resp_valid    in   in-order response strobe, no backpressure
//    imem_resp_data     in   instruction word
//    redirect_valid     in   one-cycle redirect strobe
//    redirect_pc        in   new fetch PC (bits [1:0] ignored)
//    inst_valid         out  instruction available to decoder
//    inst_ready         in   decoder consumes
//    inst, inst_pc      out  instruction word and its PC
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                 width    = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [width-1:0]   RESET_PC = width'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [width-1:0]   imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [width-1:0]   imem_resp_data,
    input  logic               redirect_valid,
    input  logic [width-1:0]   redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [width-1:0]   inst,
    output logic [width-1:0]   inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [width-1:0]   pc;
    logic [width-1:0]   resp_pc;
    logic               run;
    logic [CW-1:0]      pending;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      count;
    logic [2*width-1:0] head;
    logic               fifo_push;
    logic               fifo_pop;
    logic               req_fire;
    logic               resp_keep;
    logic [CW:0]        credit_used;
    logic [width-1:0]   target_pc;
    logic               unused_redirect_lsbs;

    assign target_pc            = {redirect_pc[width-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every queued entry and every outstanding request holds one credit, so
    // a response always finds room in the queue.
    assign credit_used    = {1'b0, count} + {1'b0, pending};
    assign imem_req_valid = run & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response is kept only outside a redirect cycle and once all stale
    // responses from before the last redirect have drained.
    assign resp_keep = imem_resp_valid & ~redirect_valid & (discard == '0);

    always_comb begin
        inst_valid = (count != '0) & ~redirect_valid;
        inst       = head[2*width-1:width];
        inst_pc    = head[width-1:0];
        fifo_push  = resp_keep;
        fifo_pop   = (count != '0) & ~redirect_valid & inst_ready;
`ifdef FETCH_BYPASS_EN
        if ((count == '0) && resp_keep) begin
            inst_valid = 1'b1;
            inst       = imem_resp_data;
            inst_pc    = resp_pc;
            // Consumed directly, so it never occupies a queue slot.
            fifo_push  = ~inst_ready;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            resp_pc <= RESET_PC;
            run     <= 1'b0;
            pending <= '0;
            discard <= '0;
        end else begin
            run     <= 1'b1;
            // req_fire is masked during redirect, so this is correct there too.
            pending <= pending + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc      <= target_pc;
                resp_pc <= target_pc;
                // Everything still in flight after this cycle is stale.
                discard <= pending - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + width'(INST_BYTES);
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + width'(INST_BYTES);
                end
                if (imem_resp_valid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .width (width),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({imem_resp_data, resp_pc}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch. An in-order memory model
//                with configurable latency answers requests with
//                data = addr ^ 32'hA5A5_0000; the decoder-side reference is
//                simply "PCs arrive in order, starting at the reset PC or the
//                latest redirect target, each carrying its own data word".
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          total;
    int          bad;
    int          cyc;
    int          nfire;
    int          nconsume;
    int          lat_min;
    int          lat_max;
    int          last_due;
    int          first_resp_cyc;
    int          first_valid_cyc;
    bit          rand_mem;
    bit          rand_dec;
    bit          mem_ready;
    bit          dec_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_addr;

    // One clock cycle: called at posedge+1, drives inputs, samples at negedge,
    // updates the models and returns at the next posedge+1.
    task automatic step(input bit redir, input logic [31:0] rpc);
        int d;
        imem_req_ready = rand_mem ? ($urandom_range(0, 3) != 0) : mem_ready;
        inst_ready     = rand_dec ? 1'($urandom_range(0, 1)) : dec_ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr ^ KEY;
            void'(mq.pop_front());
            if (first_resp_cyc < 0) first_resp_cyc = cyc;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        total++;
        if (int'(dut.discard) > int'(dut.pending)) begin
            bad++;
            $display("FAIL discard_le_pending cyc=%0d discard=%0d pending=%0d", cyc, dut.discard, dut.pending);
        end
        total++;
        if (int'(dut.count) + int'(dut.pending) > 4) begin
            bad++;
            $display("FAIL credit cyc=%0d count=%0d pending=%0d limit=4", cyc, dut.count, dut.pending);
        end
        if (imem_resp_valid) begin
            total++;
            if (dut.pending == 0) begin
                bad++;
                $display("FAIL resp_with_no_pending cyc=%0d pending=%0d required>0", cyc, dut.pending);
            end
        end
        if (redir) begin
            total++;
            if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL redirect_mask cyc=%0d inst_valid=%b req_valid=%b required 0/0", cyc, inst_valid, imem_req_valid);
            end
        end
        if (inst_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            total++;
            if (inst_pc !== exp_pc || inst !== (exp_pc ^ KEY)) begin
                bad++;
                $display("FAIL deliver cyc=%0d pc=%h inst=%h required pc=%h inst=%h", cyc, inst_pc, inst, exp_pc, exp_pc ^ KEY);
            end
            exp_pc = exp_pc + 32'd4;
            nconsume++;
        end
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            total++;
            if (imem_req_addr !== exp_req_addr) begin
                bad++;
                $display("FAIL req_addr cyc=%0d addr=%h required=%h", cyc, imem_req_addr, exp_req_addr);
            end
            d = cyc + int'($urandom_range(lat_min, lat_max));
            if (d <= last_due) d = last_due + 1;
            mq.push_back('{addr: imem_req_addr, due: d});
            last_due     = d;
            exp_req_addr = exp_req_addr + 32'd4;
            nfire++;
        end
        if (redir) begin
            exp_pc       = {rpc[31:2], 2'b00};
            exp_req_addr = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_model();
        mq.delete();
        exp_pc          = 32'h0;
        exp_req_addr    = 32'h0;
        cyc             = 0;
        nfire           = 0;
        nconsume        = 0;
        last_due        = 0;
        first_resp_cyc  = -1;
        first_valid_cyc = -1;
        rand_mem        = 1'b0;
        rand_dec        = 1'b0;
        lat_min         = 1;
        lat_max         = 1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        total++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids req_valid=%b inst_valid=%b required 0/0", imem_req_valid, inst_valid);
        end
        total++;
        if (imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr addr=%h required=00000000", imem_req_addr);
        end
        total++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_inst inst=%h inst_pc=%h required 0/0", inst, inst_pc);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL run_delay req_valid=%b required=0", imem_req_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (imem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_req req_valid=%b required=1", imem_req_valid);
        end
    endtask

    // Continues straight from test_reset: 1-cycle memory, decoder always ready.
    task automatic test_stream();
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        repeat (30) step(1'b0, 32'h0);
        total++;
        if (first_resp_cyc != 1) begin
            bad++;
            $display("FAIL first_resp_cycle got=%0d required=1", first_resp_cyc);
        end
        total++;
        if (first_valid_cyc - first_resp_cyc != 1 - BYP) begin
            bad++;
            $display("FAIL resp_to_valid_latency got=%0d required=%0d", first_valid_cyc - first_resp_cyc, 1 - BYP);
        end
        total++;
        if (nconsume != 28 + BYP) begin
            bad++;
            $display("FAIL throughput consumed=%0d required=%0d", nconsume, 28 + BYP);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_ready = 1'b1;
        dec_ready = 1'b0;
        repeat (12) step(1'b0, 32'h0);
        total++;
        if (nfire != 4 || imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL credit_stop fires=%0d req_valid=%b inst_valid=%b required 4/0/1", nfire, imem_req_valid, inst_valid);
        end
        dec_ready = 1'b1;
        repeat (12) step(1'b0, 32'h0);
        total++;
        if (nconsume < 8 || nfire < 10) begin
            bad++;
            $display("FAIL resume consumed=%0d fires=%0d required >=8/>=10", nconsume, nfire);
        end
    endtask

    task automatic test_req_stall();
        int g;
        apply_reset();
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        g = 0;
        while (nfire < 8 && g < 40) begin
            step(1'b0, 32'h0);
            g++;
        end
        total++;
        if (nfire != 8) begin
            bad++;
            $display("FAIL stall_setup fires=%0d required=8", nfire);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            total++;
            if (imem_req_addr !== 32'h20 || imem_req_valid !== 1'b1 || nfire != 8) begin
                bad++;
                $display("FAIL addr_hold i=%0d addr=%h valid=%b fires=%0d required 00000020/1/8", i, imem_req_addr, imem_req_valid, nfire);
            end
        end
        mem_ready = 1'b1;
        step(1'b0, 32'h0);
        total++;
        if (nfire != 9 || imem_req_addr !== 32'h24) begin
            bad++;
            $display("FAIL stall_release fires=%0d addr=%h required 9/00000024", nfire, imem_req_addr);
        end
    endtask

    task automatic test_redirect();
        int g;
        apply_reset();
        lat_min   = 3;
        lat_max   = 3;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        g = 0;
        while (nfire < 4 && g < 20) begin
            step(1'b0, 32'h0);
            g++;
        end
        mem_ready = 1'b0;
        g = 0;
        while (mq.size() > 2 && g < 20) begin
            step(1'b0, 32'h0);
            g++;
        end
        total++;
        if (mq.size() != 2 || nfire != 4) begin
            bad++;
            $display("FAIL redirect_setup inflight=%0d fires=%0d required 2/4", mq.size(), nfire);
        end
        step(1'b1, 32'h0000_0100);
        mem_ready = 1'b1;
        nconsume  = 0;
        repeat (20) step(1'b0, 32'h0);
        total++;
        if (nconsume < 5) begin
            bad++;
            $display("FAIL after_redirect consumed=%0d required>=5", nconsume);
        end
        // Back-to-back redirects: the second one must win.
        step(1'b1, 32'h0000_0200);
        step(1'b1, 32'h0000_0303);
        nconsume = 0;
        repeat (20) step(1'b0, 32'h0);
        total++;
        if (nconsume < 5 || exp_pc <= 32'h300 || exp_pc > 32'h340) begin
            bad++;
            $display("FAIL back_to_back consumed=%0d next_pc=%h required >=5 in (300,340]", nconsume, exp_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        apply_reset();
        lat_min  = 1;
        lat_max  = 4;
        rand_mem = 1'b1;
        rand_dec = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF6 : $urandom;
                step(1'b1, rpc);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        total++;
        if (nconsume < 60) begin
            bad++;
            $display("FAIL random_progress consumed=%0d required>=60", nconsume);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        apply_reset();
        lat_min   = 3;
        lat_max   = 3;
        mem_ready = 1'b1;
        dec_ready = 1'b0;
        g = 0;
        while (!(nfire == 4 && mq.size() == 2) && g < 30) begin
            step(1'b0, 32'h0);
            g++;
        end
        total++;
        if (inst_valid !== 1'b1 || nfire != 4 || mq.size() != 2) begin
            bad++;
            $display("FAIL midreset_setup inst_valid=%b fires=%0d inflight=%0d required 1/4/2", inst_valid, nfire, mq.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async inst_valid=%b req_valid=%b required 0/0", inst_valid, imem_req_valid);
        end
        apply_reset();
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        repeat (10) step(1'b0, 32'h0);
        total++;
        if (nconsume < 7) begin
            bad++;
            $display("FAIL midreset_restart consumed=%0d required>=7", nconsume);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        total     = 0;
        bad       = 0;
        mem_ready = 1'b0;
        dec_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
